main: RTL and testbench

MAIN -- requirements
Module: main

---
 rtl/main.sv | 251 +++++++++++++++++++++++++
 tb/tb_main.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/main.sv
// Five-stage MIPS-subset pipeline (IF/ID/EX/MEM/WB). An ALU result reaches wb_* 4 cycles after its fetch.
// No external backpressure: a load-use hazard stalls IF/ID for one cycle, a taken beq flushes two stages and j flushes one.
module main (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] instMemory [0:65535],
   input  logic [31:0] regMem     [0:31],
   output logic [31:0] pc_out,
   output logic        wb_en,
   output logic [4:0]  wb_addr,
   output logic [31:0] wb_data
);

   typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT} alu_op_t;

   typedef struct packed {
      logic       wen;
      logic [4:0] dest;
      alu_op_t    alu_op;
      logic       use_imm;
      logic       mem_rd;
      logic       mem_wr;
      logic       branch;
   } ctrl_t;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] FN_ADD   = 6'h20;
   localparam logic [5:0] FN_SUB   = 6'h22;
   localparam logic [5:0] FN_AND   = 6'h24;
   localparam logic [5:0] FN_OR    = 6'h25;
   localparam logic [5:0] FN_SLT   = 6'h2A;

   logic [31:0] r_pc;
   logic [31:0] r_ifid_instr;
   logic [31:0] r_ifid_pc;
   ctrl_t       r_idex_ctrl;
   logic [31:0] r_idex_pc;
   logic [31:0] r_idex_a;
   logic [31:0] r_idex_b;
   logic [31:0] r_idex_imm;
   logic [4:0]  r_idex_rs;
   logic [4:0]  r_idex_rt;
   logic        r_exmem_wen;
   logic [4:0]  r_exmem_dest;
   logic        r_exmem_mem_rd;
   logic        r_exmem_mem_wr;
   logic [31:0] r_exmem_alu;
   logic [31:0] r_exmem_sdata;
   logic        r_memwb_wen;
   logic [4:0]  r_memwb_dest;
   logic [31:0] r_memwb_data;
   logic [31:0] r_rf   [0:31];
   logic [31:0] r_dmem [0:1023];

   logic [31:0] w_fetch;
   logic [5:0]  w_op;
   logic [5:0]  w_funct;
   logic [4:0]  w_rs;
   logic [4:0]  w_rt;
   logic [4:0]  w_rd;
   logic [31:0] w_imm;
   logic        w_is_j;
   ctrl_t       w_ctrl;
   logic [31:0] w_rs_val;
   logic [31:0] w_rt_val;
   logic        w_stall;
   logic [31:0] w_fwd_a;
   logic [31:0] w_fwd_b;
   logic [31:0] w_alu_b;
   logic [31:0] w_alu_res;
   logic        w_beq_taken;
   logic [31:0] w_beq_target;
   logic [31:0] w_mem_rdata;
   logic [31:0] w_wb_value;

   assign w_fetch = instMemory[r_pc[15:0]];

   assign w_op    = r_ifid_instr[31:26];
   assign w_rs    = r_ifid_instr[25:21];
   assign w_rt    = r_ifid_instr[20:16];
   assign w_rd    = r_ifid_instr[15:11];
   assign w_funct = r_ifid_instr[5:0];
   assign w_imm   = {{16{r_ifid_instr[15]}}, r_ifid_instr[15:0]};
   assign w_is_j  = (w_op == OP_J);

   // Unsupported encodings fall through with all-zero control, i.e. a bubble.
   always_comb begin
      w_ctrl = '0;
      case (w_op)
         OP_RTYPE: begin
            w_ctrl.dest = w_rd;
            w_ctrl.wen  = 1'b1;
            case (w_funct)
               FN_ADD:  w_ctrl.alu_op = ALU_ADD;
               FN_SUB:  w_ctrl.alu_op = ALU_SUB;
               FN_AND:  w_ctrl.alu_op = ALU_AND;
               FN_OR:   w_ctrl.alu_op = ALU_OR;
               FN_SLT:  w_ctrl.alu_op = ALU_SLT;
               default: w_ctrl = '0;
            endcase
         end
         OP_ADDI: begin
            w_ctrl.wen     = 1'b1;
            w_ctrl.dest    = w_rt;
            w_ctrl.use_imm = 1'b1;
         end
         OP_LW: begin
            w_ctrl.wen     = 1'b1;
            w_ctrl.dest    = w_rt;
            w_ctrl.use_imm = 1'b1;
            w_ctrl.mem_rd  = 1'b1;
         end
         OP_SW: begin
            w_ctrl.use_imm = 1'b1;
            w_ctrl.mem_wr  = 1'b1;
         end
         OP_BEQ:  w_ctrl.branch = 1'b1;
         default: ;
      endcase
      if (w_ctrl.dest == 5'd0) w_ctrl.wen = 1'b0;
   end

   assign w_rs_val = (w_rs == 5'd0) ? 32'd0 :
                     (r_memwb_wen && r_memwb_dest == w_rs) ? r_memwb_data : r_rf[w_rs];
   assign w_rt_val = (w_rt == 5'd0) ? 32'd0 :
                     (r_memwb_wen && r_memwb_dest == w_rt) ? r_memwb_data : r_rf[w_rt];

   assign w_stall = r_idex_ctrl.mem_rd && (r_idex_ctrl.dest != 5'd0) &&
                    (r_idex_ctrl.dest == w_rs || r_idex_ctrl.dest == w_rt);

   // wen already implies a nonzero destination, so R0 is never forwarded.
   assign w_fwd_a = (r_exmem_wen && r_exmem_dest == r_idex_rs) ? r_exmem_alu :
                    (r_memwb_wen && r_memwb_dest == r_idex_rs) ? r_memwb_data : r_idex_a;
   assign w_fwd_b = (r_exmem_wen && r_exmem_dest == r_idex_rt) ? r_exmem_alu :
                    (r_memwb_wen && r_memwb_dest == r_idex_rt) ? r_memwb_data : r_idex_b;
   assign w_alu_b = r_idex_ctrl.use_imm ? r_idex_imm : w_fwd_b;

   always_comb begin
      w_alu_res = '0;
      case (r_idex_ctrl.alu_op)
         ALU_ADD: w_alu_res = w_fwd_a + w_alu_b;
         ALU_SUB: w_alu_res = w_fwd_a - w_alu_b;
         ALU_AND: w_alu_res = w_fwd_a & w_alu_b;
         ALU_OR:  w_alu_res = w_fwd_a | w_alu_b;
         ALU_SLT: w_alu_res = {31'd0, ($signed(w_fwd_a) < $signed(w_alu_b))};
         default: ;
      endcase
   end

   assign w_beq_taken  = r_idex_ctrl.branch && (w_fwd_a == w_fwd_b);
   assign w_beq_target = r_idex_pc + 32'd1 + r_idex_imm;

   assign w_mem_rdata = r_dmem[r_exmem_alu[9:0]];
   assign w_wb_value  = r_exmem_mem_rd ? w_mem_rdata : r_exmem_alu;

   // Redirect priority: taken beq in EX, then load-use stall, then j in ID.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_pc         <= '0;
         r_ifid_instr <= '0;
         r_ifid_pc    <= '0;
      end else if (w_beq_taken) begin
         r_pc         <= w_beq_target;
         r_ifid_instr <= '0;
         r_ifid_pc    <= '0;
      end else if (!w_stall) begin
         r_pc         <= w_is_j ? {6'd0, r_ifid_instr[25:0]} : r_pc + 32'd1;
         r_ifid_instr <= w_is_j ? 32'd0 : w_fetch;
         r_ifid_pc    <= r_pc;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_idex_ctrl <= '0;
         r_idex_pc   <= '0;
         r_idex_a    <= '0;
         r_idex_b    <= '0;
         r_idex_imm  <= '0;
         r_idex_rs   <= '0;
         r_idex_rt   <= '0;
      end else if (w_beq_taken || w_stall) begin
         r_idex_ctrl <= '0;
         r_idex_pc   <= '0;
         r_idex_a    <= '0;
         r_idex_b    <= '0;
         r_idex_imm  <= '0;
         r_idex_rs   <= '0;
         r_idex_rt   <= '0;
      end else begin
         r_idex_ctrl <= w_ctrl;
         r_idex_pc   <= r_ifid_pc;
         r_idex_a    <= w_rs_val;
         r_idex_b    <= w_rt_val;
         r_idex_imm  <= w_imm;
         r_idex_rs   <= w_rs;
         r_idex_rt   <= w_rt;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_exmem_wen    <= 1'b0;
         r_exmem_dest   <= '0;
         r_exmem_mem_rd <= 1'b0;
         r_exmem_mem_wr <= 1'b0;
         r_exmem_alu    <= '0;
         r_exmem_sdata  <= '0;
         r_memwb_wen    <= 1'b0;
         r_memwb_dest   <= '0;
         r_memwb_data   <= '0;
      end else begin
         r_exmem_wen    <= r_idex_ctrl.wen;
         r_exmem_dest   <= r_idex_ctrl.dest;
         r_exmem_mem_rd <= r_idex_ctrl.mem_rd;
         r_exmem_mem_wr <= r_idex_ctrl.mem_wr;
         r_exmem_alu    <= w_alu_res;
         r_exmem_sdata  <= w_fwd_b;
         r_memwb_wen    <= r_exmem_wen;
         r_memwb_dest   <= r_exmem_dest;
         r_memwb_data   <= w_wb_value;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < 32; i++) r_rf[i] <= (i == 0) ? 32'd0 : regMem[i];
      end else if (r_memwb_wen) begin
         r_rf[r_memwb_dest] <= r_memwb_data;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < 1024; i++) r_dmem[i] <= '0;
      end else if (r_exmem_mem_wr) begin
         r_dmem[r_exmem_alu[9:0]] <= r_exmem_sdata;
      end
   end

   assign pc_out  = r_pc;
   assign wb_en   = r_memwb_wen;
   assign wb_addr = r_memwb_dest;
   assign wb_data = r_memwb_data;

endmodule

// File: tb/tb_main.sv
// Bench for the MIPS-subset pipeline: single-instruction vector table, hand-timed hazard/branch/reset
// sequences, and random programs compared in program order against an instruction-level interpreter.
module tb_main;
   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] imem [0:65535];
   logic [31:0] rmem [0:31];
   logic [31:0] pc_out;
   logic        wb_en;
   logic [4:0]  wb_addr;
   logic [31:0] wb_data;

   main dut (
      .clk(clk), .rst(rst), .instMemory(imem), .regMem(rmem),
      .pc_out(pc_out), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   always @(posedge clk or negedge rst) begin
      if (!rst) cyc <= 0;
      else      cyc <= cyc + 1;
   end

   logic [4:0]  got_a [$];
   logic [31:0] got_d [$];
   int          got_c [$];

   always @(negedge clk) begin
      if (rst === 1'b1 && wb_en === 1'b1) begin
         got_a.push_back(wb_addr);
         got_d.push_back(wb_data);
         got_c.push_back(cyc);
      end
   end

   logic [4:0]  exp_a [$];
   logic [31:0] exp_d [$];
   logic [31:0] mr [0:31];
   logic [31:0] mm [0:1023];

   typedef struct {
      string       name;
      logic [31:0] instr;
      logic        exp_en;
      logic [4:0]  exp_addr;
      logic [31:0] exp_data;
   } vec_t;
   vec_t vq [$];

   function automatic logic [31:0] enc_r(input logic [5:0] fn, input logic [4:0] rd,
                                         input logic [4:0] rs, input logic [4:0] rt);
      return {6'h00, rs, rt, rd, 5'd0, fn};
   endfunction

   function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rt,
                                         input logic [4:0] rs, input logic [15:0] imm);
      return {op, rs, rt, imm};
   endfunction

   function automatic logic [31:0] enc_j(input logic [25:0] tgt);
      return {6'h02, tgt};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic expect_wb(input string name, input int idx, input logic [4:0] a,
                            input logic [31:0] d, input int c);
      if (idx < got_a.size()) begin
         check({name, "_addr"}, {27'd0, got_a[idx]}, {27'd0, a});
         check({name, "_data"}, got_d[idx], d);
         check({name, "_cyc"}, got_c[idx], c);
      end else begin
         checks++;
         errors++;
         $display("FAIL %s: write #%0d missing, only %0d writes seen", name, idx, got_a.size());
      end
   endtask

   task automatic add_vec(input string n, input logic [31:0] ins, input logic en,
                          input logic [4:0] a, input logic [31:0] d);
      vec_t v;
      v.name = n; v.instr = ins; v.exp_en = en; v.exp_addr = a; v.exp_data = d;
      vq.push_back(v);
   endtask

   task automatic clear_prog();
      for (int i = 0; i < 64; i++) imem[i] = 32'h0;
   endtask

   task automatic regs_identity();
      for (int i = 0; i < 32; i++) rmem[i] = 32'(i);
   endtask

   task automatic do_reset();
      rst = 1'b0;
      got_a.delete(); got_d.delete(); got_c.delete();
      repeat (2) @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic wait_cyc(input int k);
      while (cyc < k) @(negedge clk);
   endtask

   // Instruction-level interpreter: one instruction at a time, no notion of pipeline timing.
   task automatic run_model();
      int pc, pc_next, steps;
      logic [31:0] ins, a, b, imm, res, addr;
      logic [4:0]  rs, rt, rd, dst;
      logic [5:0]  op, fn;
      logic        do_w;
      exp_a.delete(); exp_d.delete();
      for (int i = 0; i < 32; i++) mr[i] = (i == 0) ? 32'd0 : rmem[i];
      for (int i = 0; i < 1024; i++) mm[i] = 32'd0;
      pc = 0;
      steps = 0;
      while (pc < 64 && steps < 1000) begin
         ins = imem[pc];
         op = ins[31:26]; rs = ins[25:21]; rt = ins[20:16]; rd = ins[15:11]; fn = ins[5:0];
         a = mr[rs]; b = mr[rt];
         imm = {{16{ins[15]}}, ins[15:0]};
         addr = a + imm;
         do_w = 1'b0; dst = 5'd0; res = 32'd0;
         pc_next = pc + 1;
         case (op)
            6'h00: begin
               dst = rd; do_w = 1'b1;
               case (fn)
                  6'h20: res = a + b;
                  6'h22: res = a - b;
                  6'h24: res = a & b;
                  6'h25: res = a | b;
                  6'h2A: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                  default: do_w = 1'b0;
               endcase
            end
            6'h08: begin dst = rt; do_w = 1'b1; res = a + imm; end
            6'h23: begin dst = rt; do_w = 1'b1; res = mm[addr[9:0]]; end
            6'h2B: mm[addr[9:0]] = b;
            6'h04: if (a == b) pc_next = pc + 1 + int'($signed(imm));
            6'h02: pc_next = int'({6'd0, ins[25:0]});
            default: ;
         endcase
         if (do_w && dst != 5'd0) begin
            mr[dst] = res;
            exp_a.push_back(dst);
            exp_d.push_back(res);
         end
         pc = pc_next;
         steps++;
      end
   endtask

   // Forward-only control flow keeps every random program finite.
   function automatic logic [31:0] gen_instr(input int pc);
      int kind;
      logic [4:0] rd, rs, rt;
      logic [31:0] w;
      kind = $urandom_range(0, 10);
      rd = 5'($urandom_range(0, 7));
      rs = 5'($urandom_range(0, 7));
      rt = 5'($urandom_range(0, 7));
      case (kind)
         0: return enc_r(6'h20, rd, rs, rt);
         1: return enc_r(6'h22, rd, rs, rt);
         2: return enc_r(6'h24, rd, rs, rt);
         3: return enc_r(6'h25, rd, rs, rt);
         4: return enc_r(6'h2A, rd, rs, rt);
         5: return enc_i(6'h08, rd, rs, 16'($urandom));
         6: return enc_i(6'h23, rd, 5'($urandom_range(0, 2)), 16'($urandom_range(0, 7)));
         7: return enc_i(6'h2B, rt, 5'($urandom_range(0, 2)), 16'($urandom_range(0, 7)));
         8: return enc_i(6'h04, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                         16'($urandom_range(0, 3)));
         9: return enc_j(26'(pc + 1 + int'($urandom_range(0, 3))));
         default: begin
            w = $urandom;
            if (w[31:26] == 6'h02 || w[31:26] == 6'h04) w[31:26] = 6'h3F;
            return w;
         end
      endcase
   endfunction

   initial begin
      rst = 1'b1;
      for (int i = 0; i < 65536; i++) imem[i] = 32'h0;
      regs_identity();
      #2 rst = 1'b0;

      add_vec("v_add",      enc_r(6'h20, 5'd3, 5'd1, 5'd0),   1'b1, 5'd3,  32'd1);
      add_vec("v_sub",      enc_r(6'h22, 5'd6, 5'd5, 5'd4),   1'b1, 5'd6,  32'd1);
      add_vec("v_and",      enc_r(6'h24, 5'd9, 5'd7, 5'd8),   1'b1, 5'd9,  32'd0);
      add_vec("v_or",       enc_r(6'h25, 5'd12, 5'd10, 5'd11), 1'b1, 5'd12, 32'd11);
      add_vec("v_slt_t",    enc_r(6'h2A, 5'd15, 5'd13, 5'd14), 1'b1, 5'd15, 32'd1);
      add_vec("v_slt_f",    enc_r(6'h2A, 5'd15, 5'd14, 5'd13), 1'b1, 5'd15, 32'd0);
      add_vec("v_sub_wrap", enc_r(6'h22, 5'd2, 5'd0, 5'd3),   1'b1, 5'd2,  32'hFFFF_FFFD);
      add_vec("v_addi_neg", enc_i(6'h08, 5'd5, 5'd2, 16'hFFFD), 1'b1, 5'd5, 32'hFFFF_FFFF);
      add_vec("v_addi_pos", enc_i(6'h08, 5'd6, 5'd4, 16'h7FFF), 1'b1, 5'd6, 32'h0000_8003);
      add_vec("v_funct0",   enc_r(6'h00, 5'd7, 5'd1, 5'd2),   1'b0, 5'd0,  32'd0);
      add_vec("v_zero",     32'h0000_0000,                    1'b0, 5'd0,  32'd0);
      add_vec("v_r0_dest",  enc_r(6'h20, 5'd0, 5'd1, 5'd2),   1'b0, 5'd0,  32'd0);
      add_vec("v_bad_op",   32'hFFFF_FFFF,                    1'b0, 5'd0,  32'd0);

      repeat (2) @(negedge clk);
      check("rst_pc", pc_out, 32'd0);
      check("rst_wb_en", {31'd0, wb_en}, 32'd0);
      check("rst_wb_addr", {27'd0, wb_addr}, 32'd0);
      check("rst_wb_data", wb_data, 32'd0);

      // First result timing after reset release.
      clear_prog();
      imem[0] = enc_r(6'h20, 5'd3, 5'd1, 5'd0);
      do_reset();
      for (int k = 1; k <= 3; k++) begin
         wait_cyc(k);
         check("lat_idle_en", {31'd0, wb_en}, 32'd0);
      end
      wait_cyc(4);
      check("lat_en", {31'd0, wb_en}, 32'd1);
      check("lat_addr", {27'd0, wb_addr}, 32'd3);
      check("lat_data", wb_data, 32'd1);
      check("lat_pc", pc_out, 32'd4);

      for (int i = 0; i < vq.size(); i++) begin
         clear_prog();
         regs_identity();
         imem[0] = vq[i].instr;
         do_reset();
         wait_cyc(4);
         check({vq[i].name, "_en"}, {31'd0, wb_en}, {31'd0, vq[i].exp_en});
         if (vq[i].exp_en) begin
            check({vq[i].name, "_addr"}, {27'd0, wb_addr}, {27'd0, vq[i].exp_addr});
            check({vq[i].name, "_data"}, wb_data, vq[i].exp_data);
         end
         wait_cyc(8);
         check({vq[i].name, "_count"}, got_a.size(), {31'd0, vq[i].exp_en});
      end

      // Back-to-back dependent adds.
      clear_prog();
      imem[0] = enc_r(6'h20, 5'd3, 5'd1, 5'd2);
      imem[1] = enc_r(6'h20, 5'd4, 5'd2, 5'd3);
      imem[2] = enc_r(6'h20, 5'd5, 5'd3, 5'd4);
      do_reset();
      wait_cyc(10);
      check("fwd_count", got_a.size(), 32'd3);
      expect_wb("fwd0", 0, 5'd3, 32'd3, 4);
      expect_wb("fwd1", 1, 5'd4, 32'd5, 5);
      expect_wb("fwd2", 2, 5'd5, 32'd8, 6);

      // Taken beq at PC 6 to PC 10.
      clear_prog();
      imem[0]  = enc_r(6'h20, 5'd3, 5'd1, 5'd0);
      imem[6]  = enc_i(6'h04, 5'd3, 5'd1, 16'd3);
      imem[7]  = enc_r(6'h20, 5'd20, 5'd1, 5'd1);
      imem[8]  = enc_r(6'h20, 5'd21, 5'd1, 5'd1);
      imem[9]  = enc_r(6'h20, 5'd22, 5'd1, 5'd1);
      imem[10] = enc_r(6'h20, 5'd23, 5'd1, 5'd2);
      do_reset();
      wait_cyc(8);
      check("beq_pc_before", pc_out, 32'd8);
      wait_cyc(9);
      check("beq_pc_target", pc_out, 32'd10);
      wait_cyc(16);
      check("beq_count", got_a.size(), 32'd2);
      expect_wb("beq0", 0, 5'd3, 32'd1, 4);
      expect_wb("beq1", 1, 5'd23, 32'd3, 13);

      // Store, load, then dependent use: one stall cycle.
      clear_prog();
      imem[0] = enc_i(6'h2B, 5'd3, 5'd0, 16'd5);
      imem[1] = enc_i(6'h23, 5'd16, 5'd0, 16'd5);
      imem[2] = enc_r(6'h20, 5'd17, 5'd16, 5'd1);
      do_reset();
      wait_cyc(4);
      check("lu_pc_held", pc_out, 32'd3);
      wait_cyc(10);
      check("lu_count", got_a.size(), 32'd2);
      expect_wb("lu_lw", 0, 5'd16, 32'd3, 5);
      expect_wb("lu_add", 1, 5'd17, 32'd4, 7);

      // j resolved in ID with a one-slot flush.
      clear_prog();
      imem[0] = enc_j(26'd5);
      imem[1] = enc_r(6'h20, 5'd20, 5'd1, 5'd1);
      imem[5] = enc_r(6'h20, 5'd21, 5'd2, 5'd2);
      do_reset();
      wait_cyc(2);
      check("j_pc", pc_out, 32'd5);
      wait_cyc(10);
      check("j_count", got_a.size(), 32'd1);
      expect_wb("j0", 0, 5'd21, 32'd4, 6);

      // Taken beq in EX and j in ID on the same cycle.
      clear_prog();
      imem[0]  = enc_i(6'h04, 5'd0, 5'd0, 16'd4);
      imem[1]  = enc_j(26'd20);
      imem[5]  = enc_r(6'h20, 5'd21, 5'd1, 5'd1);
      imem[20] = enc_r(6'h20, 5'd22, 5'd1, 5'd1);
      do_reset();
      wait_cyc(3);
      check("bj_pc", pc_out, 32'd5);
      wait_cyc(12);
      check("bj_count", got_a.size(), 32'd1);
      expect_wb("bj0", 0, 5'd21, 32'd2, 7);

      // Reset pulled mid-program, then state must come back from regMem with data memory cleared.
      clear_prog();
      imem[0] = enc_i(6'h08, 5'd3, 5'd0, 16'd100);
      imem[1] = enc_i(6'h08, 5'd4, 5'd0, 16'd200);
      imem[2] = enc_i(6'h2B, 5'd3, 5'd0, 16'd9);
      imem[3] = enc_r(6'h20, 5'd5, 5'd3, 5'd4);
      do_reset();
      wait_cyc(5);
      check("mid_pre_en", {31'd0, wb_en}, 32'd1);
      check("mid_pre_data", wb_data, 32'd200);
      rst = 1'b0;
      #1;
      check("mid_pc", pc_out, 32'd0);
      check("mid_wb_en", {31'd0, wb_en}, 32'd0);
      check("mid_wb_addr", {27'd0, wb_addr}, 32'd0);
      clear_prog();
      imem[0] = enc_r(6'h20, 5'd7, 5'd3, 5'd4);
      imem[1] = enc_i(6'h23, 5'd9, 5'd0, 16'd9);
      do_reset();
      wait_cyc(9);
      check("mid_count", got_a.size(), 32'd2);
      expect_wb("mid_reg", 0, 5'd7, 32'd7, 4);
      expect_wb("mid_mem", 1, 5'd9, 32'd0, 5);

      // Random programs against the interpreter, compared as an ordered write stream.
      for (int t = 0; t < 25; t++) begin
         clear_prog();
         for (int i = 0; i < 32; i++) rmem[i] = $urandom;
         for (int p = 0; p < 40; p++) imem[p] = gen_instr(p);
         run_model();
         do_reset();
         wait_cyc(250);
         check("rand_count", got_a.size(), exp_a.size());
         for (int i = 0; i < got_a.size() && i < exp_a.size(); i++) begin
            check("rand_addr", {27'd0, got_a[i]}, {27'd0, exp_a[i]});
            check("rand_data", got_d[i], exp_d[i]);
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
